// File: rtl/reg_bus_sequencer_pkg.sv
// Shared types for the register-bus sequencer: command opcodes, FSM states,
// and the data/count widths used by the interface and the sequencer.
package reg_bus_pkg;

    localparam int DATA_W  = 32;
    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_CMP  = 3'd4,
        S_RSP  = 3'd5
    } state_e;

    // The reserved encoding 3 is folded onto READ so the FSM only sees legal ops.
    function automatic op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'd0:    return OP_WRITE;
            2'd2:    return OP_POLL;
            default: return OP_READ;
        endcase
    endfunction

endpackage

// File: rtl/reg_bus_sequencer_if.sv
// Command stream, response stream and register-bus signals of the sequencer.
// master = the sequencer itself, slave = the host/peripheral environment.
interface reg_bus_sequencer_if #(
    parameter int pADDRESS_BITS = 4
);
    import reg_bus_pkg::*;

    // command stream
    logic                     iCMD_VALID;
    logic                     oCMD_READY;
    logic [1:0]               iCMD_OP;
    logic [pADDRESS_BITS-1:0] iCMD_ADDRESS;
    logic [DATA_W-1:0]        iCMD_DATA;
    logic [DATA_W-1:0]        iCMD_MASK;

    // response stream
    logic                     oRSP_VALID;
    logic                     iRSP_READY;
    logic [DATA_W-1:0]        oRSP_DATA;
    logic                     oRSP_TIMEOUT;
    logic [COUNT_W-1:0]       oRSP_COUNT;

    // register bus
    logic [pADDRESS_BITS-1:0] oADDRESS;
    logic                     oWRITE;
    logic                     oREAD;
    logic [DATA_W-1:0]        oWRITE_DATA;
    logic [DATA_W-1:0]        iREAD_DATA;

    logic                     oBUSY;

    modport master (
        input  iCMD_VALID, iCMD_OP, iCMD_ADDRESS, iCMD_DATA, iCMD_MASK,
        input  iRSP_READY, iREAD_DATA,
        output oCMD_READY, oRSP_VALID, oRSP_DATA, oRSP_TIMEOUT, oRSP_COUNT,
        output oADDRESS, oWRITE, oREAD, oWRITE_DATA, oBUSY
    );

    modport slave (
        output iCMD_VALID, iCMD_OP, iCMD_ADDRESS, iCMD_DATA, iCMD_MASK,
        output iRSP_READY, iREAD_DATA,
        input  oCMD_READY, oRSP_VALID, oRSP_DATA, oRSP_TIMEOUT, oRSP_COUNT,
        input  oADDRESS, oWRITE, oREAD, oWRITE_DATA, oBUSY
    );

endinterface

// File: rtl/reg_bus_sequencer.sv
// Register-bus initiator: executes WRITE, READ and POLL-until-match commands
// on a single-cycle address/write/read bus with registered read data.
// All outputs are registered; read/poll results leave on the response stream.
module reg_bus_sequencer
    import reg_bus_pkg::*;
#(
    parameter int pADDRESS_BITS = 4,
    parameter int pREAD_LATENCY = 1,    // 1..15
    parameter int pPOLL_LIMIT   = 255   // 1..65535
) (
    input  logic                iCLOCK,
    input  logic                iRESET,
    reg_bus_sequencer_if.master bus
);

    localparam logic [3:0]         LP_LAT_LAST = 4'(pREAD_LATENCY - 1);
    localparam logic [COUNT_W-1:0] LP_LIMIT    = COUNT_W'(pPOLL_LIMIT);

    state_e                   r_state;
    op_e                      r_op;
    logic [DATA_W-1:0]        r_cmd_data;
    logic [DATA_W-1:0]        r_cmd_mask;
    logic [3:0]               r_lat_cnt;

    logic                     r_cmd_ready;
    logic                     r_rsp_valid;
    logic [DATA_W-1:0]        r_rsp_data;
    logic                     r_rsp_timeout;
    logic [COUNT_W-1:0]       r_rsp_count;
    logic [pADDRESS_BITS-1:0] r_address;
    logic                     r_write;
    logic                     r_read;
    logic [DATA_W-1:0]        r_write_data;
    logic                     r_busy;

    logic                     w_accept;
    op_e                      w_cmd_op;
    logic                     w_match;
    logic [COUNT_W-1:0]       w_count_inc;

    assign w_cmd_op    = decode_op(bus.iCMD_OP);
    assign w_accept    = (r_state == S_IDLE) && r_cmd_ready && bus.iCMD_VALID;
    // r_rsp_data holds the value captured at the end of WAIT.
    assign w_match     = ((r_rsp_data & r_cmd_mask) == (r_cmd_data & r_cmd_mask));
    // Saturating read counter; unreachable with the legal poll-limit range.
    assign w_count_inc = (r_rsp_count == '1) ? r_rsp_count : r_rsp_count + 1'b1;

    // Command FSM; every output is a register updated on the state transition.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            r_state       <= S_IDLE;
            r_op          <= OP_WRITE;
            r_cmd_data    <= '0;
            r_cmd_mask    <= '0;
            r_lat_cnt     <= '0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_rsp_count   <= '0;
            r_address     <= '0;
            r_write       <= 1'b0;
            r_read        <= 1'b0;
            r_write_data  <= '0;
            r_busy        <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a branch below re-arms them.
            r_write <= 1'b0;
            r_read  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_op        <= w_cmd_op;
                        r_address   <= bus.iCMD_ADDRESS;
                        r_cmd_data  <= bus.iCMD_DATA;
                        r_cmd_mask  <= bus.iCMD_MASK;
                        r_rsp_count <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_cmd_op == OP_WRITE) begin
                            r_write      <= 1'b1;
                            r_write_data <= bus.iCMD_DATA;
                            r_state      <= S_WR;
                        end else begin
                            r_read  <= 1'b1;
                            r_state <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                S_RD: begin
                    r_rsp_count <= w_count_inc;
                    r_lat_cnt   <= LP_LAT_LAST;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_rsp_data <= bus.iREAD_DATA;
                        r_state    <= S_CMP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                S_CMP: begin
                    if (r_op != OP_POLL || w_match) begin
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RSP;
                    end else if (r_rsp_count == LP_LIMIT) begin
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RSP;
                    end else begin
                        r_read  <= 1'b1;
                        r_state <= S_RD;
                    end
                end
                S_RSP: begin
                    if (bus.iRSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oCMD_READY   = r_cmd_ready;
    assign bus.oRSP_VALID   = r_rsp_valid;
    assign bus.oRSP_DATA    = r_rsp_data;
    assign bus.oRSP_TIMEOUT = r_rsp_timeout;
    assign bus.oRSP_COUNT   = r_rsp_count;
    assign bus.oADDRESS     = r_address;
    assign bus.oWRITE       = r_write;
    assign bus.oREAD        = r_read;
    assign bus.oWRITE_DATA  = r_write_data;
    assign bus.oBUSY        = r_busy;

endmodule

// File: doc/reg_bus_sequencer.md
Name: reg_bus_sequencer

Overview:
- Register-bus initiator. Takes commands from a valid/ready stream and drives the single-cycle address/write/read register interface used by the PIO-style peripherals in this codebase (registered read data, no wait-request).
- Supports single write, single read, and hardware poll-until-match, so a soft core or host bridge can offload register sequences.
- Read and poll results return on a valid/ready response stream.

Parameters:
- pADDRESS_BITS, 4, width of oADDRESS and iCMD_ADDRESS.
- pREAD_LATENCY, 1, cycles from the oREAD cycle to valid iREAD_DATA. Legal range is 1..15.
- pPOLL_LIMIT, 255, maximum reads per POLL command before timeout. Legal range is 1..65535.

Ports:
- iCLOCK  in  1  single clock; all logic on the rising edge.
- iRESET  in  1  synchronous, active-high reset.
- iCMD_VALID  in  1  command valid.
- oCMD_READY  out  1  command accepted when iCMD_VALID and oCMD_READY are both high.
- iCMD_OP  in  2  operation: 0 WRITE, 1 READ, 2 POLL, 3 reserved (treated as READ).
- iCMD_ADDRESS  in  pADDRESS_BITS  target register.
- iCMD_DATA  in  32  write data (WRITE) or match value (POLL).
- iCMD_MASK  in  32  compare mask (POLL only).
- oRSP_VALID  out  1  response valid.
- iRSP_READY  in  1  response consumed.
- oRSP_DATA  out  32  read data; for POLL, the last value read.
- oRSP_TIMEOUT  out  1  POLL hit pPOLL_LIMIT without a match.
- oRSP_COUNT  out  16  number of reads performed by this command.
- oADDRESS  out  pADDRESS_BITS  bus address.
- oWRITE  out  1  bus write strobe.
- oREAD  out  1  bus read strobe.
- oWRITE_DATA  out  32  bus write data.
- iREAD_DATA  in  32  bus read data.
- oBUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - While iRESET is high at a clock edge: state becomes IDLE.
  - All outputs go to 0 (oCMD_READY becomes 1 the cycle after reset deasserts).
  - Internal command, latency and poll counters are cleared.
  - Reset mid-transaction abandons it: no response is produced and a pending oRSP_VALID is dropped.
- Outputs are registered. oADDRESS and oWRITE_DATA hold their last values when not strobed.
- oCMD_READY is 1 only in IDLE. On accept, op, address, data and mask are latched, and oRSP_COUNT is cleared.
- State machine: IDLE, WR, RD, WAIT, CMP, RSP.
  - IDLE, accept WRITE -> WR. oWRITE=1 for exactly one cycle in WR, with the latched address and data. WR -> IDLE. Writes produce no response. Back-to-back writes have one strobe every 2 cycles.
  - IDLE, accept READ or POLL -> RD.
  - RD: oREAD=1 for exactly one cycle; oRSP_COUNT increments. -> WAIT.
  - WAIT: lasts pREAD_LATENCY cycles. iREAD_DATA is sampled at the end of the last WAIT cycle. With latency 1, the data valid in the cycle after the oREAD cycle is captured. -> CMP.
  - CMP, READ: -> RSP with oRSP_TIMEOUT=0.
  - CMP, POLL, match ((data & mask) == (cmd_data & mask)): -> RSP, timeout=0.
  - CMP, POLL, no match, oRSP_COUNT == pPOLL_LIMIT: -> RSP, timeout=1.
  - CMP, POLL, no match, otherwise: -> RD. This gives at least 2 idle bus cycles between reads.
  - RSP: oRSP_VALID=1. Data, timeout and count are held stable until iRSP_READY. The handshake cycle -> IDLE; no new command is accepted in that same cycle.
- Strobes: oWRITE and oREAD are never high together and are never high outside WR/RD.
- Mask 0 on POLL matches on the first read (count=1).
- oRSP_COUNT saturates at 16 bits, which cannot be reached given the pPOLL_LIMIT range.
- Reserved op 3 behaves as READ.
- An iCMD_VALID held high while not ready has no effect.

Decomposition:
- Package reg_bus_pkg holds:
  - op enum (OP_WRITE=0, OP_READ=1, OP_POLL=2).
  - state enum.
  - localparams for data width (32) and count width (16).
- Sub-module: none required. The latency/poll counters are small and stay inline; a single module is preferred.

Test Plan:
1. Reset -> all outputs 0. Then WRITE addr=1 data=0x0000_00FF -> exactly one oWRITE pulse with oADDRESS=1, oWRITE_DATA=0xFF, and no oRSP_VALID.
2. READ addr=0, bus model returns 0xA5A5_0001 one cycle after oREAD -> oRSP_VALID with data 0xA5A5_0001, timeout=0, count=1. Hold iRSP_READY low 5 cycles -> response stays stable.
3. POLL addr=0, mask=0x1, match=0x1; model returns 0x0 for 3 reads, then 0x3 -> 4 oREAD pulses, response data=0x3, count=4, timeout=0.
4. pPOLL_LIMIT=8, POLL that never matches -> exactly 8 oREAD pulses, timeout=1, count=8, data = last value read.
5. pREAD_LATENCY=3, READ -> data is captured 3 cycles after the oREAD cycle, and a wrong value on the bus at +1/+2 is ignored.
6. Assert iRESET during WAIT of a POLL -> no response, oBUSY=0 and oCMD_READY=1 after release. A following READ completes normally.
